// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a combinational instruction memory
// and queues {pc, instruction} pairs in a 2-entry buffer toward decode.
module instruction_fetch_unit #(
    parameter int                  WORDSIZE         = 64,
    parameter int                  INSTRUCTION_SIZE = 32,
    parameter int                  MEMORY_SIZE      = 1024,
    parameter logic [WORDSIZE-1:0] RESET_PC         = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fetch_enable,
    input  logic                        redirect_valid,
    input  logic [WORDSIZE-1:0]         redirect_pc,
    output logic [WORDSIZE-1:0]         imem_addr,
    input  logic [INSTRUCTION_SIZE-1:0] imem_instruction,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INSTRUCTION_SIZE-1:0] out_instruction,
    output logic [WORDSIZE-1:0]         out_pc,
    output logic                        fault,
    output logic [1:0]                  state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t                      cur_state;
    state_t                      nxt_state;
    logic [WORDSIZE-1:0]         pc;
    logic [WORDSIZE-1:0]         buf_pc  [2];
    logic [INSTRUCTION_SIZE-1:0] buf_ins [2];
    logic                        rd_ptr;
    logic                        wr_ptr;
    logic [1:0]                  count;
    logic                        pop;
    logic                        push;
    logic                        halt_fetch;
    logic                        has_space;
    logic                        in_range;
    logic                        redirect_ok;

    assign imem_addr       = pc >> 2;
    assign in_range        = imem_addr < WORDSIZE'(MEMORY_SIZE);
    assign out_valid       = (count != 2'd0);
    assign pop             = out_valid & out_ready;
    assign has_space       = (count != 2'd2) | pop;
    assign redirect_ok     = (redirect_pc[1:0] == 2'b00);
    assign out_pc          = buf_pc[rd_ptr];
    assign out_instruction = buf_ins[rd_ptr];
    assign state           = cur_state;
    // Tail slot; when full the tail aliases the head, which is only written while it pops.
    assign wr_ptr          = rd_ptr ^ count[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        if (redirect_valid) begin
            if (redirect_ok) begin
                nxt_state = fetch_enable ? FETCH : IDLE;
            end else begin
                nxt_state = HALT;
            end
        end else begin
            case (cur_state)
                IDLE:    if (fetch_enable) nxt_state = FETCH;
                FETCH: begin
                    if (!fetch_enable) begin
                        nxt_state = IDLE;
                    end else if (has_space && !in_range) begin
                        nxt_state = HALT;
                    end
                end
                default: nxt_state = HALT;
            endcase
        end
    end

    always_comb begin
        push       = 1'b0;
        halt_fetch = 1'b0;
        if (cur_state == FETCH && fetch_enable && !redirect_valid && has_space) begin
            if (in_range) begin
                push = 1'b1;
            end else begin
                halt_fetch = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            fault      <= 1'b0;
            count      <= 2'd0;
            rd_ptr     <= 1'b0;
            buf_pc[0]  <= '0;
            buf_pc[1]  <= '0;
            buf_ins[0] <= '0;
            buf_ins[1] <= '0;
        end else if (redirect_valid) begin
            // Flush wins over any same-cycle pop or push.
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            if (redirect_ok) begin
                pc    <= redirect_pc;
                fault <= 1'b0;
            end else begin
                fault <= 1'b1;
            end
        end else begin
            if (push) begin
                buf_pc[wr_ptr]  <= pc;
                buf_ins[wr_ptr] <= imem_instruction;
                pc              <= pc + WORDSIZE'(4);
            end
            if (halt_fetch) fault <= 1'b1;
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random traffic,
// all checked against a queue-based reference model of the fetch behaviour.
module tb_instruction_fetch_unit;

    localparam int W   = 64;
    localparam int IW  = 32;
    localparam int MEM = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_enable = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [W-1:0]  redirect_pc = '0;
    logic [W-1:0]  imem_addr;
    logic [IW-1:0] imem_instruction;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_instruction;
    logic [W-1:0]  out_pc;
    logic          fault;
    logic [1:0]    state;

    logic [IW-1:0] mem [MEM];
    logic [IW-1:0] init_ins [4] = '{32'h06B38183, 32'hB6799A23, 32'h007981B3, 32'h41FC8333};

    // Reference model
    logic [W-1:0]  m_pc;
    logic          m_fault;
    int            m_st;
    logic [W-1:0]  q_pc  [$];
    logic [IW-1:0] q_ins [$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign imem_instruction = (imem_addr < W'(MEM)) ? mem[imem_addr[3:0]] : 32'hDEADBEEF;

    instruction_fetch_unit #(
        .WORDSIZE(W),
        .INSTRUCTION_SIZE(IW),
        .MEMORY_SIZE(MEM),
        .RESET_PC('0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fetch_enable(fetch_enable),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_addr(imem_addr),
        .imem_instruction(imem_instruction),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instruction(out_instruction),
        .out_pc(out_pc),
        .fault(fault),
        .state(state)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_pc    = '0;
        m_fault = 1'b0;
        m_st    = 0;
        q_pc.delete();
        q_ins.delete();
    endtask

    task automatic compare_all();
        chk("valid", out_valid, (q_pc.size() != 0));
        if (q_pc.size() != 0) begin
            chk("out_pc", out_pc, q_pc[0]);
            chk("out_ins", out_instruction, q_ins[0]);
        end
        chk("fault", fault, m_fault);
        chk("state", state, m_st);
        chk("imem_addr", imem_addr, m_pc >> 2);
    endtask

    // Compare, advance the model by one clock using current inputs, then clock the DUT.
    task automatic step();
        int           sz;
        bit           pop;
        logic [W-1:0] slot;
        compare_all();
        sz  = q_pc.size();
        pop = (sz != 0) && out_ready;
        if (redirect_valid) begin
            q_pc.delete();
            q_ins.delete();
            if (redirect_pc[1:0] == 2'b00) begin
                m_pc    = redirect_pc;
                m_fault = 1'b0;
                m_st    = fetch_enable ? 1 : 0;
            end else begin
                m_fault = 1'b1;
                m_st    = 2;
            end
        end else begin
            if (pop) begin
                void'(q_pc.pop_front());
                void'(q_ins.pop_front());
            end
            case (m_st)
                0: if (fetch_enable) m_st = 1;
                1: begin
                    if (!fetch_enable) begin
                        m_st = 0;
                    end else if (sz < 2 || pop) begin
                        slot = m_pc >> 2;
                        if (slot < W'(MEM)) begin
                            q_pc.push_back(m_pc);
                            q_ins.push_back(mem[slot[3:0]]);
                            m_pc = m_pc + 64'd4;
                        end else begin
                            m_st    = 2;
                            m_fault = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [W-1:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < MEM; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[i] = init_ins[i];
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_ins", out_instruction, 0);

        // Reset release and start-up
        fetch_enable = 1'b1;
        out_ready    = 1'b1;
        rst_n        = 1'b1;
        step();
        chk("start_valid_e1", out_valid, 0);
        step();
        chk("start_valid_e2", out_valid, 1);
        for (int i = 0; i < 4; i++) begin
            chk("start_pc", out_pc, 64'(4 * i));
            chk("start_ins", out_instruction, init_ins[i]);
            step();
        end
        chk("start_fault", fault, 0);

        // Backpressure
        out_ready = 1'b0;
        do_redirect(64'h0);
        repeat (5) step();
        chk("bp_addr", imem_addr, 2);
        chk("bp_head", out_pc, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_drain", out_pc, 64'(4 * i));
            step();
        end

        // Legal redirect with two entries buffered
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        do_redirect(64'h20);
        chk("rd_flush", out_valid, 0);
        step();
        chk("rd_valid", out_valid, 1);
        chk("rd_pc0", out_pc, 64'h20);
        step();
        chk("rd_pc1", out_pc, 64'h24);

        // Misaligned redirect, then recovery
        do_redirect(64'h22);
        chk("mis_fault", fault, 1);
        chk("mis_state", state, 2);
        repeat (3) step();
        chk("mis_nopush", out_valid, 0);
        do_redirect(64'h10);
        chk("rec_fault", fault, 0);
        chk("rec_state", state, 1);
        step();
        chk("rec_valid", out_valid, 1);
        chk("rec_pc", out_pc, 64'h10);

        // End of memory
        do_redirect(64'h38);
        step();
        chk("eom_pc0", out_pc, 64'h38);
        step();
        chk("eom_pc1", out_pc, 64'h3C);
        step();
        chk("eom_fault", fault, 1);
        chk("eom_state", state, 2);
        chk("eom_addr", imem_addr, 16);
        repeat (2) step();
        chk("eom_nowrap", imem_addr, 16);
        chk("eom_empty", out_valid, 0);

        // Random traffic with an asynchronous reset in the middle
        do_redirect(64'h0);
        for (int n = 0; n < 600; n++) begin
            logic [1:0] lo;
            fetch_enable   = ($urandom_range(0, 9) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            lo             = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            redirect_pc    = (W'($urandom_range(0, 17)) << 2) | W'(lo);
            if (n == 300) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("arst_valid", out_valid, 0);
                chk("arst_fault", fault, 0);
                chk("arst_state", state, 0);
                chk("arst_addr", imem_addr, 0);
                model_reset();
                rst_n = 1'b1;
            end
            step();
        end
        redirect_valid = 1'b0;
        compare_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
